// File: rtl/baud_pkg.sv
// Shared defaults and the divisor arithmetic used to derive the reset-time baud divisor.
package baud_pkg;

   localparam int unsigned CLK_HZ_DEF     = 50_000_000;
   localparam int unsigned BAUD_DEF       = 115_200;
   localparam int unsigned OVERSAMPLE_DEF = 16;
   localparam int unsigned PHASE_W        = $clog2(OVERSAMPLE_DEF);

   typedef logic [PHASE_W-1:0] phase_t;

   // Fixed-point clk/os-tick ratio; the integer part sits above frac_w, the fraction below.
   function automatic longint unsigned div_quotient(input longint unsigned clk_hz,
                                                    input longint unsigned baud,
                                                    input longint unsigned os,
                                                    input int unsigned     frac_w);
      return (clk_hz << frac_w) / (baud * os);
   endfunction

endpackage

// File: rtl/baud_nco.sv
// Fractional down-counter: fire is combinational (en && cnt==0), interval div_int + carry cycles.
// No backpressure; load_new restarts the fraction and suppresses the carry for that reload.
module baud_nco #(
   parameter int DIV_INT_W  = 16,
   parameter int DIV_FRAC_W = 8
) (
   input  logic                  clk50,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic                  load_new,
   input  logic [DIV_INT_W-1:0]  div_int,
   input  logic [DIV_FRAC_W-1:0] div_frac,
   output logic                  fire
);

   logic [DIV_INT_W-1:0]  cnt;
   logic [DIV_FRAC_W-1:0] acc;
   logic [DIV_FRAC_W:0]   sum;
   logic                  carry;

   assign fire  = en && (cnt == '0);
   assign sum   = {1'b0, acc} + {1'b0, div_frac};
   assign carry = sum[DIV_FRAC_W] && !load_new;

   always_ff @(posedge clk50 or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
         acc <= '0;
      end else if (!en) begin
         cnt <= '0;
         acc <= '0;
      end else if (fire) begin
         cnt <= div_int - DIV_INT_W'(1) + DIV_INT_W'(carry);
         acc <= load_new ? '0 : sum[DIV_FRAC_W-1:0];
      end else begin
         cnt <= cnt - DIV_INT_W'(1);
      end
   end

endmodule

// File: rtl/baud_gen_frac.sv
// Programmable fractional UART baud generator: os/tx/rx-mid ticks registered one cycle after fire.
// div_ready drops after an accepted update and returns once it is applied; no queueing.
module baud_gen_frac
   import baud_pkg::*;
#(
   parameter int CLK_HZ     = CLK_HZ_DEF,
   parameter int BAUD       = BAUD_DEF,
   parameter int OVERSAMPLE = OVERSAMPLE_DEF,
   parameter int DIV_INT_W  = 16,
   parameter int DIV_FRAC_W = 8
) (
   input  logic                  clk50,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic [DIV_INT_W-1:0]  div_int,
   input  logic [DIV_FRAC_W-1:0] div_frac,
   input  logic                  div_valid,
   output logic                  div_ready,
   input  logic                  rx_resync,
   output logic                  os_tick,
   output logic                  tx_tick,
   output logic                  rx_mid_tick
);

   localparam longint unsigned DIV_Q = div_quotient(64'(CLK_HZ), 64'(BAUD), 64'(OVERSAMPLE),
                                                    DIV_FRAC_W);
   localparam logic [DIV_INT_W-1:0]  DEFAULT_INT  = DIV_INT_W'(DIV_Q >> DIV_FRAC_W);
   localparam logic [DIV_FRAC_W-1:0] DEFAULT_FRAC = DIV_FRAC_W'(DIV_Q);
   localparam int PH_W = $clog2(OVERSAMPLE);

   typedef logic [PH_W-1:0] ph_t;

   localparam ph_t PH_LAST = ph_t'(OVERSAMPLE - 1);
   localparam ph_t PH_MID  = ph_t'(OVERSAMPLE / 2 - 1);

   logic [DIV_INT_W-1:0]  cur_int, pend_int, nco_int, int_clamped;
   logic [DIV_FRAC_W-1:0] cur_frac, pend_frac, nco_frac;
   logic                  pend, accept, apply, fire;
   ph_t                   tx_ph, rx_ph;

   assign accept      = div_valid && div_ready;
   // With en low there is no fire to wait for, so a pending divisor lands straight away.
   assign apply       = pend && (fire || !en);
   assign int_clamped = (div_int < DIV_INT_W'(2)) ? DIV_INT_W'(2) : div_int;
   assign nco_int     = apply ? pend_int  : cur_int;
   assign nco_frac    = apply ? pend_frac : cur_frac;

   baud_nco #(
      .DIV_INT_W  (DIV_INT_W),
      .DIV_FRAC_W (DIV_FRAC_W)
   ) u_nco (
      .clk50    (clk50),
      .rst_n    (rst_n),
      .en       (en),
      .load_new (apply),
      .div_int  (nco_int),
      .div_frac (nco_frac),
      .fire     (fire)
   );

   always_ff @(posedge clk50 or negedge rst_n) begin
      if (!rst_n) begin
         cur_int   <= DEFAULT_INT;
         cur_frac  <= DEFAULT_FRAC;
         pend      <= 1'b0;
         pend_int  <= '0;
         pend_frac <= '0;
         div_ready <= 1'b1;
      end else if (apply) begin
         cur_int   <= pend_int;
         cur_frac  <= pend_frac;
         pend      <= 1'b0;
         div_ready <= 1'b1;
      end else if (accept) begin
         pend      <= 1'b1;
         pend_int  <= int_clamped;
         pend_frac <= div_frac;
         div_ready <= 1'b0;
      end
   end

   always_ff @(posedge clk50 or negedge rst_n) begin
      if (!rst_n) begin
         tx_ph <= '0;
         rx_ph <= '0;
      end else if (!en) begin
         tx_ph <= '0;
         rx_ph <= '0;
      end else begin
         if (fire) begin
            tx_ph <= (tx_ph == PH_LAST) ? '0 : tx_ph + ph_t'(1);
         end
         // A start edge re-phases RX even when it lands on a fire cycle.
         if (rx_resync) begin
            rx_ph <= '0;
         end else if (fire) begin
            rx_ph <= (rx_ph == PH_LAST) ? '0 : rx_ph + ph_t'(1);
         end
      end
   end

   always_ff @(posedge clk50 or negedge rst_n) begin
      if (!rst_n) begin
         os_tick     <= 1'b0;
         tx_tick     <= 1'b0;
         rx_mid_tick <= 1'b0;
      end else begin
         os_tick     <= fire;
         tx_tick     <= fire && (tx_ph == PH_LAST);
         rx_mid_tick <= fire && (rx_ph == PH_MID);
      end
   end

endmodule
